// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem sequencer and IF/ID register.
// Handles wait states, load-use stalls, flushes and jump/branch redirects without losing or duplicating fetches.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PCWrite,
   input  logic        IF2ID_write,
   input  logic        IF2ID_flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC,
   output logic [31:0] IF2ID_instr,
   output logic [31:0] IF2ID_PC_plus4,
   output logic        IF2ID_valid,
   output logic        fetch_busy
);

   localparam logic [1:0] S_FETCH   = 2'd0;
   localparam logic [1:0] S_DISCARD = 2'd1;
   localparam logic [1:0] S_HOLD    = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] old_q, old_d;
   logic [31:0] pend_q, pend_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcp4_q, pcp4_d;
   logic        valid_q, valid_d;

   logic        taken, advance, deliver;
   logic [31:0] target, dl_instr, dl_pc;
   logic        unused_bits;

   assign unused_bits = ^redirect_pc[1:0];
   assign target      = {redirect_pc[31:2], 2'b00};
   assign taken       = redirect_valid & PCWrite;
   // A flush blocks delivery so that the word is parked in HOLD instead of dropped.
   assign advance     = PCWrite & IF2ID_write & ~IF2ID_flush;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      old_d    = old_q;
      pend_d   = pend_q;
      buf_d    = buf_q;
      buf_pc_d = buf_pc_q;
      deliver  = 1'b0;
      dl_instr = imem_rdata;
      dl_pc    = pc_q;
      case (state_q)
         S_FETCH: begin
            if (taken) begin
               pc_d = target;
               if (!imem_ack) begin
                  pend_d  = target;
                  old_d   = pc_q;
                  state_d = S_DISCARD;
               end
            end else if (imem_ack) begin
               if (advance) begin
                  deliver = 1'b1;
                  pc_d    = pc_q + 32'd4;
               end else begin
                  buf_d    = imem_rdata;
                  buf_pc_d = pc_q;
                  state_d  = S_HOLD;
               end
            end
         end
         S_DISCARD: begin
            if (taken) begin
               pend_d = target;
               pc_d   = target;
            end
            if (imem_ack) begin
               pc_d    = taken ? target : pend_q;
               state_d = S_FETCH;
            end
         end
         S_HOLD: begin
            dl_instr = buf_q;
            dl_pc    = buf_pc_q;
            if (taken) begin
               pc_d    = target;
               state_d = S_FETCH;
            end else if (advance) begin
               deliver = 1'b1;
               pc_d    = pc_q + 32'd4;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase

      instr_d = instr_q;
      pcp4_d  = pcp4_q;
      valid_d = valid_q;
      if (IF2ID_flush || (IF2ID_write && !deliver)) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (IF2ID_write) begin
         instr_d = dl_instr;
         pcp4_d  = dl_pc + 32'd4;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         old_q    <= 32'd0;
         pend_q   <= 32'd0;
         buf_q    <= 32'd0;
         buf_pc_q <= 32'd0;
         instr_q  <= NOP_INSTR;
         pcp4_q   <= 32'd0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         old_q    <= old_d;
         pend_q   <= pend_d;
         buf_q    <= buf_d;
         buf_pc_q <= buf_pc_d;
         instr_q  <= instr_d;
         pcp4_q   <= pcp4_d;
         valid_q  <= valid_d;
      end
   end

   // While discarding, the bus must keep the address of the abandoned request.
   assign imem_req       = ((state_q == S_FETCH) || (state_q == S_DISCARD)) && !reset;
   assign imem_addr      = (state_q == S_DISCARD) ? old_q : pc_q;
   assign PC             = pc_q;
   assign IF2ID_instr    = instr_q;
   assign IF2ID_PC_plus4 = pcp4_q;
   assign IF2ID_valid    = valid_q;
   assign fetch_busy     = (state_q == S_DISCARD) || (imem_req && !imem_ack);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: stimulus pushes expected IF/ID contents, a monitor pops on each IF/ID load.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        PCWrite = 1'b1, IF2ID_write = 1'b1, IF2ID_flush = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        imem_req, imem_ack = 1'b0;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] PC, IF2ID_instr, IF2ID_PC_plus4;
   logic        IF2ID_valid, fetch_busy;

   int          n_cmp = 0, n_bad = 0;
   logic        ld = 1'b0;
   logic [63:0] exp_q[$];

   if_fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF2ID_write(IF2ID_write),
      .IF2ID_flush(IF2ID_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .PC(PC), .IF2ID_instr(IF2ID_instr), .IF2ID_PC_plus4(IF2ID_PC_plus4),
      .IF2ID_valid(IF2ID_valid), .fetch_busy(fetch_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   assign imem_rdata = mem(imem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] a);
      exp_q.push_back({mem(a), a + 32'd4});
   endtask

   task automatic cyc(input logic r, input logic a, input logic pw, input logic iw,
                      input logic fl, input logic rv, input logic [31:0] rp);
      @(posedge clk);
      #1;
      reset = r; imem_ack = a; PCWrite = pw; IF2ID_write = iw;
      IF2ID_flush = fl; redirect_valid = rv; redirect_pc = rp;
      #1;
   endtask

   always @(posedge clk) ld <= reset | IF2ID_write | IF2ID_flush;

   always @(negedge clk) begin
      if (ld) begin
         if (IF2ID_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL ifid_unexpected: got instr %h pc4 %h expected none", IF2ID_instr, IF2ID_PC_plus4);
            end else begin
               logic [63:0] e;
               e = exp_q.pop_front();
               chk("ifid_instr", IF2ID_instr, e[63:32]);
               chk("ifid_pc4", IF2ID_PC_plus4, e[31:0]);
            end
         end else begin
            chk("bubble_instr", IF2ID_instr, NOP);
         end
      end
   end

   initial begin
      // reset
      cyc(1, 0, 1, 1, 0, 0, 0);
      cyc(1, 0, 1, 1, 0, 0, 0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_pc", PC, 32'd0);
      chk("rst_valid", {31'd0, IF2ID_valid}, 32'd0);
      chk("rst_pc4", IF2ID_PC_plus4, 32'd0);
      // zero-wait streaming
      cyc(0, 1, 1, 1, 0, 0, 0); chk("addr0", imem_addr, 32'd0); chk("req0", {31'd0, imem_req}, 32'd1); push(32'd0);
      cyc(0, 1, 1, 1, 0, 0, 0); chk("addr4", imem_addr, 32'd4); push(32'd4);
      // two wait states at 8
      cyc(0, 0, 1, 1, 0, 0, 0); chk("wait_addr8a", imem_addr, 32'd8); chk("wait_busy", {31'd0, fetch_busy}, 32'd1);
      cyc(0, 0, 1, 1, 0, 0, 0); chk("wait_addr8b", imem_addr, 32'd8);
      cyc(0, 1, 1, 1, 0, 0, 0); chk("wait_addr8c", imem_addr, 32'd8); push(32'd8);
      cyc(0, 1, 1, 1, 0, 0, 0); chk("addr12", imem_addr, 32'd12); push(32'd12);
      // stall into HOLD at 16
      cyc(0, 1, 0, 0, 0, 0, 0); chk("addr16", imem_addr, 32'd16);
      cyc(0, 0, 1, 1, 0, 0, 0); chk("hold_req", {31'd0, imem_req}, 32'd0); chk("hold_pc", PC, 32'd16); push(32'd16);
      // redirect while 0x14 unacked, overwritten to 0x40, ack 3 cycles later
      cyc(0, 0, 1, 1, 0, 1, 32'h60); chk("pc20", PC, 32'd20);
      cyc(0, 0, 1, 1, 0, 1, 32'h40); chk("disc_pc", PC, 32'h60); chk("disc_addr", imem_addr, 32'h14);
      chk("disc_busy", {31'd0, fetch_busy}, 32'd1);
      cyc(0, 0, 1, 1, 0, 0, 0); chk("disc_pc2", PC, 32'h40); chk("disc_addr2", imem_addr, 32'h14);
      cyc(0, 1, 1, 1, 0, 0, 0);
      cyc(0, 1, 1, 1, 0, 0, 0); chk("redir_addr", imem_addr, 32'h40); push(32'h40);
      // redirect + flush + ack together, unaligned target
      cyc(0, 1, 1, 1, 1, 1, 32'h103); chk("addr44", imem_addr, 32'h44);
      cyc(0, 1, 1, 1, 0, 0, 0); chk("pc100", PC, 32'h100); push(32'h100);
      // flush + ack without redirect parks the word
      cyc(0, 1, 1, 1, 1, 0, 0); chk("addr104", imem_addr, 32'h104);
      cyc(0, 0, 1, 1, 0, 0, 0); chk("flhold_req", {31'd0, imem_req}, 32'd0); push(32'h104);
      // reset in HOLD
      cyc(0, 1, 0, 0, 0, 0, 0); chk("pc108", PC, 32'h108);
      cyc(1, 0, 1, 1, 0, 0, 0); chk("rsth_req", {31'd0, imem_req}, 32'd0);
      cyc(0, 0, 1, 1, 0, 0, 0); chk("rsth_pc", PC, 32'd0); chk("rsth_valid", {31'd0, IF2ID_valid}, 32'd0);
      chk("rsth_pc4", IF2ID_PC_plus4, 32'd0); chk("rsth_req1", {31'd0, imem_req}, 32'd1);
      // reset in DISCARD
      cyc(0, 0, 1, 1, 0, 1, 32'h200);
      cyc(1, 0, 1, 1, 0, 0, 0); chk("rstd_pc_pre", PC, 32'h200); chk("rstd_busy", {31'd0, fetch_busy}, 32'd1);
      cyc(0, 0, 1, 1, 0, 0, 0); chk("rstd_pc", PC, 32'd0); chk("rstd_addr", imem_addr, 32'd0);
      // PC wrap
      cyc(0, 1, 1, 1, 0, 1, 32'hFFFF_FFFC);
      cyc(0, 1, 1, 1, 0, 0, 0); chk("pc_top", PC, 32'hFFFF_FFFC); push(32'hFFFF_FFFC);
      // redirect ignored while PCWrite=0
      cyc(0, 0, 0, 1, 0, 1, 32'h300); chk("wrap_pc", PC, 32'd0);
      cyc(0, 0, 1, 1, 0, 0, 0); chk("ignored_redir", PC, 32'd0);
      cyc(0, 0, 1, 1, 0, 0, 0);
      cyc(0, 0, 1, 1, 0, 0, 0);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
